// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type for mem_arbiter and its helpers
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner select, first set req at or above ptr, wrapping
// Ports: req (request vector), ptr (scan start), valid (any request), win (winner index)
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic               valid,
  output logic [PW-1:0]      win
);
  logic [PW-1:0] lo, hi;
  logic hi_v;
  // Descending scan leaves the lowest match: hi is the lowest set bit at/above ptr,
  // lo the lowest overall, which is the wrapped winner when nothing sits at/above ptr.
  always_comb begin
    lo = '0;
    hi = '0;
    hi_v = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j]) lo = PW'(j);
      if (req[j] && PW'(j) >= ptr) begin
        hi = PW'(j);
        hi_v = 1'b1;
      end
    end
  end
  assign valid = |req;
  assign win = hi_v ? hi : lo;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory read port among NUM_REQ single-word read requesters
// Ports: req/addr from requesters; gnt/rvalid/rdata/busy back to them;
//        mem_address/mem_read to memory; mem_readdata/mem_readdatavalid/mem_waitrequest from it.
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic                          mem_read,
  input  logic [DATA_WIDTH-1:0]         mem_readdata,
  input  logic                          mem_readdatavalid,
  input  logic                          mem_waitrequest
);
  localparam int PW = $clog2(NUM_REQ);
  arb_state_e state, state_d;
  logic [PW-1:0] owner, win, ptr;
  logic [ADDR_WIDTH-1:0] addr_q, addr_sel;
  logic valid;
  logic done;
  assign done = state == WAIT_DATA && mem_readdatavalid;
`ifdef MEM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PW-1:0] rr_ptr;
  assign ptr = rr_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (done) rr_ptr <= owner == PW'(NUM_REQ - 1) ? '0 : owner + PW'(1);
`endif
  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req(req),
    .ptr(ptr),
    .valid(valid),
    .win(win)
  );
  always_comb begin
    addr_sel = '0;
    for (int j = 0; j < NUM_REQ; j++)
      if (PW'(j) == win) addr_sel = addr[j*ADDR_WIDTH +: ADDR_WIDTH];
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = valid ? ISSUE : IDLE;
      ISSUE:     state_d = mem_waitrequest ? ISSUE : WAIT_DATA;
      WAIT_DATA: state_d = mem_readdatavalid ? IDLE : WAIT_DATA;
      default:   state_d = IDLE;
    endcase
    mem_read = state == ISSUE;
    busy = state != IDLE;
    gnt = (state == ISSUE && !mem_waitrequest) ? NUM_REQ'(1) << owner : '0;
  end
  assign mem_address = addr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      addr_q <= '0;
      rvalid <= '0;
      rdata <= '0;
    end else begin
      state <= state_d;
      rvalid <= done ? NUM_REQ'(1) << owner : '0;
      if (state == IDLE && valid) begin
        owner <= win;
        addr_q <= addr_sel;
      end
      if (done) rdata <= mem_readdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int N = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata;
  logic busy;
  logic [AW-1:0] mem_address;
  logic mem_read;
  logic [DW-1:0] mem_readdata = '0;
  logic mem_readdatavalid = 1'b0;
  logic mem_waitrequest = 1'b0;
  int errors = 0;
  int checks = 0;
  int m_ptr = 0;
  logic [DW-1:0] m_data = '0;

  mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .addr(addr),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata),
    .busy(busy),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid),
    .mem_waitrequest(mem_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] v);
    addr[i*AW +: AW] = v;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef MEM_ARB_FIXED_PRIO_EN
    p = 0;
`endif
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    mem_waitrequest = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    m_ptr = 0;
    m_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    settle();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %0h want 0", gnt); end
    checks++; if (rvalid !== '0) begin errors++; $display("FAIL reset_rvalid: got %0h want 0", rvalid); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %0h want 0", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %0b want 0", mem_read); end
    checks++; if (mem_address !== '0) begin errors++; $display("FAIL reset_mem_address: got %0h want 0", mem_address); end
    cyc();
    rst_n = 1'b1;
    m_ptr = 0;
    m_data = '0;
  endtask

  task automatic test_single();
    set_addr(0, 32'h5);
    cyc();
    req = 3'b001;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_c0_busy: got %0b want 0", busy); end
    cyc();
    settle();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_c1_gnt: got %0h want 1", gnt); end
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL single_c1_mem_read: got %0b want 1", mem_read); end
    checks++; if (mem_address !== 32'h5) begin errors++; $display("FAIL single_c1_addr: got %0h want 5", mem_address); end
    cyc();
    req = '0;
    settle();
    checks++; if (gnt !== '0 || mem_read !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_c2_wait: gnt=%0h mem_read=%0b busy=%0b want 0/0/1", gnt, mem_read, busy); end
    cyc();
    cyc();
    mem_readdatavalid = 1'b1;
    mem_readdata = 64'hDEAD_BEEF_0000_0005;
    settle();
    checks++; if (rvalid !== '0) begin errors++; $display("FAIL single_c4_rvalid: got %0h want 0", rvalid); end
    cyc();
    mem_readdatavalid = 1'b0;
    mem_readdata = '0;
    settle();
    checks++; if (rvalid !== 3'b001) begin errors++; $display("FAIL single_c5_rvalid: got %0h want 1", rvalid); end
    checks++; if (rdata !== 64'hDEAD_BEEF_0000_0005) begin errors++; $display("FAIL single_c5_rdata: got %0h want deadbeef00000005", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_c5_busy: got %0b want 0", busy); end
    m_data = 64'hDEAD_BEEF_0000_0005;
    m_ptr = 1;
  endtask

  task automatic test_spurious();
    cyc();
    mem_readdatavalid = 1'b1;
    mem_readdata = 64'h1234;
    settle();
    cyc();
    mem_readdatavalid = 1'b0;
    settle();
    checks++; if (rvalid !== '0) begin errors++; $display("FAIL spurious_rvalid: got %0h want 0", rvalid); end
    checks++; if (rdata !== m_data) begin errors++; $display("FAIL spurious_rdata: got %0h want %0h", rdata, m_data); end
  endtask

  task automatic test_reset_mid();
    set_addr(1, 32'h77);
    cyc();
    req = 3'b010;
    settle();
    cyc();
    settle();
    cyc();
    req = '0;
    settle();
    checks++; if (busy !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL rmid_wait: busy=%0b mem_read=%0b want 1/0", busy, mem_read); end
    rst_n = 1'b0;
    settle();
    checks++; if (busy !== 1'b0 || gnt !== '0 || rvalid !== '0 || mem_read !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: busy=%0b gnt=%0h rvalid=%0h mem_read=%0b want 0", busy, gnt, rvalid, mem_read); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL rmid_rdata: got %0h want 0", rdata); end
    checks++; if (mem_address !== '0) begin errors++; $display("FAIL rmid_addr: got %0h want 0", mem_address); end
    cyc();
    rst_n = 1'b1;
    m_ptr = 0;
    m_data = '0;
    cyc();
    mem_readdatavalid = 1'b1;
    mem_readdata = 64'hBAD;
    settle();
    cyc();
    mem_readdatavalid = 1'b0;
    settle();
    checks++; if (rvalid !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_late_rdv: rvalid=%0h busy=%0b want 0/0", rvalid, busy); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL rmid_late_rdata: got %0h want 0", rdata); end
    set_addr(0, 32'hA0);
    set_addr(2, 32'hA2);
    req = 3'b111;
    cyc();
    settle();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rmid_first_gnt: got %0h want 1", gnt); end
    checks++; if (mem_address !== 32'hA0) begin errors++; $display("FAIL rmid_first_addr: got %0h want a0", mem_address); end
    cyc();
    req = '0;
    mem_readdatavalid = 1'b1;
    mem_readdata = 64'hC0;
    settle();
    cyc();
    mem_readdatavalid = 1'b0;
    settle();
    checks++; if (rvalid !== 3'b001 || rdata !== 64'hC0) begin errors++; $display("FAIL rmid_first_rvalid: rvalid=%0h rdata=%0h want 1/c0", rvalid, rdata); end
    m_data = 64'hC0;
    m_ptr = 1;
  endtask

  task automatic test_waitrequest();
    logic [N-1:0] eg;
    set_addr(2, 32'h22);
    cyc();
    req = 3'b100;
    settle();
    for (int i = 0; i < 5; i++) begin
      cyc();
      mem_waitrequest = i < 4;
      settle();
      eg = i < 4 ? 3'b000 : 3'b100;
      checks++; if (mem_read !== 1'b1 || mem_address !== 32'h22) begin errors++; $display("FAIL wait_hold_%0d: mem_read=%0b addr=%0h want 1/22", i, mem_read, mem_address); end
      checks++; if (gnt !== eg) begin errors++; $display("FAIL wait_gnt_%0d: got %0h want %0h", i, gnt, eg); end
    end
    cyc();
    req = '0;
    mem_waitrequest = 1'b0;
    mem_readdatavalid = 1'b1;
    mem_readdata = 64'h22AA;
    settle();
    cyc();
    mem_readdatavalid = 1'b0;
    settle();
    checks++; if (rvalid !== 3'b100 || rdata !== 64'h22AA) begin errors++; $display("FAIL wait_rvalid: rvalid=%0h rdata=%0h want 4/22aa", rvalid, rdata); end
    m_data = 64'h22AA;
    m_ptr = 0;
  endtask

  task automatic test_drop();
    set_addr(1, 32'h11);
    cyc();
    req = 3'b010;
    settle();
    cyc();
    mem_waitrequest = 1'b1;
    settle();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL drop_c1_gnt: got %0h want 0", gnt); end
    cyc();
    req = '0;
    mem_waitrequest = 1'b0;
    settle();
    checks++; if (gnt !== 3'b010 || mem_address !== 32'h11) begin errors++; $display("FAIL drop_gnt: gnt=%0h addr=%0h want 2/11", gnt, mem_address); end
    cyc();
    mem_readdatavalid = 1'b1;
    mem_readdata = 64'h11BB;
    settle();
    cyc();
    mem_readdatavalid = 1'b0;
    settle();
    checks++; if (rvalid !== 3'b010 || rdata !== 64'h11BB) begin errors++; $display("FAIL drop_rvalid: rvalid=%0h rdata=%0h want 2/11bb", rvalid, rdata); end
  endtask

  // Transaction-level reference: the bench plays requesters and memory, and
  // predicts gnt/rvalid/busy/mem_read from round-robin arithmetic on m_ptr.
  task automatic run_traffic(input int ncyc, input bit held, input string tag);
    int phase = 0;
    int cur = 0;
    int lat = 0;
    int gcount = 0;
    logic [AW-1:0] cur_addr = '0;
    logic [N-1:0] r = '0;
    logic [N-1:0] exp_rv = '0;
    logic [N-1:0] exp_g;
    logic [N-1:0] last_g = '0;
    bit w, v;
    logic [DW-1:0] d;
    apply_reset();
    if (held) begin
      set_addr(0, 32'h100);
      set_addr(1, 32'h101);
    end
    for (int c = 0; c < ncyc; c++) begin
      cyc();
      if (held) r = 3'b011;
      else
        for (int i = 0; i < N; i++)
          if (!r[i] && $urandom_range(0, 2) == 0) begin
            r[i] = 1'b1;
            set_addr(i, $urandom);
          end
      req = r;
      w = held ? 1'b0 : ($urandom_range(0, 2) == 0);
      v = phase == 2 ? lat == 0 : (!held && $urandom_range(0, 3) == 0);
      d = {$urandom, $urandom};
      mem_waitrequest = w;
      mem_readdatavalid = v;
      mem_readdata = d;
      settle();
      exp_g = (phase == 1 && !w) ? N'(1) << cur : '0;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL %s_gnt c%0d: got %0h want %0h", tag, c, gnt, exp_g); end
      checks++; if (rvalid !== exp_rv) begin errors++; $display("FAIL %s_rvalid c%0d: got %0h want %0h", tag, c, rvalid, exp_rv); end
      checks++; if (rdata !== m_data) begin errors++; $display("FAIL %s_rdata c%0d: got %0h want %0h", tag, c, rdata, m_data); end
      checks++; if (busy !== (phase != 0) || mem_read !== (phase == 1)) begin errors++; $display("FAIL %s_ctrl c%0d: busy=%0b mem_read=%0b phase=%0d", tag, c, busy, mem_read, phase); end
      if (phase == 1) begin
        checks++; if (mem_address !== cur_addr) begin errors++; $display("FAIL %s_addr c%0d: got %0h want %0h", tag, c, mem_address, cur_addr); end
      end
      if (held && gnt != '0) begin
        checks++;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (gnt !== 3'b001) begin errors++; $display("FAIL %s_prio c%0d: got %0h want 1", tag, c, gnt); end
`else
        if (gnt === last_g) begin errors++; $display("FAIL %s_alternate c%0d: got %0h again, want other requester", tag, c, gnt); end
`endif
        last_g = gnt;
      end
      exp_rv = '0;
      if (phase == 0) begin
        cur = pick(r, m_ptr);
        if (cur >= 0) begin
          cur_addr = addr[cur*AW +: AW];
          phase = 1;
        end
      end else if (phase == 1) begin
        if (!w) begin
          phase = 2;
          lat = $urandom_range(0, 3);
          gcount++;
          if (!held && $urandom_range(0, 1) == 1) r[cur] = 1'b0;
        end
      end else if (v) begin
        exp_rv = N'(1) << cur;
        m_data = d;
        m_ptr = (cur + 1) % N;
        phase = 0;
      end else lat--;
    end
    checks++; if (gcount < ncyc / 12) begin errors++; $display("FAIL %s_progress: got %0d grants want at least %0d", tag, gcount, ncyc / 12); end
  endtask

  task automatic test_back_to_back();
    run_traffic(80, 1'b1, "b2b");
  endtask

  task automatic test_random();
    run_traffic(1500, 1'b0, "rand");
  endtask

  initial begin
    test_reset();
    test_single();
    test_spurious();
    test_reset_mid();
    test_waitrequest();
    test_drop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
